// File: rtl/mem_ctrl.sv
// Byte-serial RAM port owner: arbitrates store > load > fetch and assembles/splits words.
// Optional MEM_IO_STALL_EN: stores to the IO region wait while the UART buffer is full.
module mem_ctrl #(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter logic [1:0] IO_SEL_HI = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_rob_misbranch,
    input  logic              in_fetcher_ce,
    input  logic [ADDR_W-1:0] in_fetcher_addr,
    output logic              out_fetcher_ce,
    output logic [DATA_W-1:0] out_fetcher_data,
    input  logic              in_lsb_ce,
    input  logic [5:0]        in_lsb_size,
    input  logic              in_lsb_signed,
    input  logic [ADDR_W-1:0] in_lsb_addr,
    output logic              out_lsb_ce,
    output logic [DATA_W-1:0] out_lsb_data,
    input  logic              in_rob_ce,
    input  logic [5:0]        in_rob_size,
    input  logic [ADDR_W-1:0] in_rob_addr,
    input  logic [DATA_W-1:0] in_rob_data,
    output logic              out_rob_ce,
    input  logic [7:0]        in_ram_din,
    output logic [7:0]        out_ram_dout,
    output logic [ADDR_W-1:0] out_ram_a,
    output logic              out_ram_wr,
    input  logic              in_io_buffer_full
);
    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_cnt, w_cnt_next, r_len, w_len_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next, r_ram_a, w_ram_a_next;
    logic              r_signed, w_signed_next, r_is_fetch, w_is_fetch_next;
    logic [DATA_W-1:0] r_wdata, w_wdata_next, r_rdata, w_rdata_next;
    logic [DATA_W-1:0] r_fetch_data, w_fetch_data_next, r_lsb_data, w_lsb_data_next;
    logic              r_fetch_ce, w_fetch_ce_next, r_lsb_ce, w_lsb_ce_next;
    logic              r_rob_ce, w_rob_ce_next, r_ram_wr, w_ram_wr_next;
    logic [7:0]        r_ram_dout, w_ram_dout_next;
    logic [DATA_W-1:0] w_rdata_cap, w_ext;
    logic [1:0]        w_cap_idx;
    logic              w_stall_cur, w_stall_new;

    function automatic logic [2:0] f_len(input logic [5:0] size);
        return (size == 6'd1) ? 3'd1 : (size == 6'd2) ? 3'd2 : 3'd4;
    endfunction

    // Byte captured on this edge was addressed two edges ago, i.e. index r_cnt-1.
    assign w_cap_idx = r_cnt[1:0] - 2'd1;
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_rdata_cap[8*gi +: 8] = (w_cap_idx == 2'(gi)) ? in_ram_din : r_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_ext = w_rdata_cap;
        case (r_len)
            3'd1:    w_ext = {{(DATA_W-8){r_signed & w_rdata_cap[7]}}, w_rdata_cap[7:0]};
            3'd2:    w_ext = {{(DATA_W-16){r_signed & w_rdata_cap[15]}}, w_rdata_cap[15:0]};
            default: w_ext = w_rdata_cap;
        endcase
    end

`ifdef MEM_IO_STALL_EN
    assign w_stall_cur = in_io_buffer_full && (r_addr[17:16] == IO_SEL_HI);
    assign w_stall_new = in_io_buffer_full && (in_rob_addr[17:16] == IO_SEL_HI);
`else
    logic w_unused_io;
    assign w_unused_io = in_io_buffer_full | (|IO_SEL_HI);
    assign w_stall_cur = 1'b0;
    assign w_stall_new = 1'b0;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_len_next        = r_len;
        w_addr_next       = r_addr;
        w_signed_next     = r_signed;
        w_is_fetch_next   = r_is_fetch;
        w_wdata_next      = r_wdata;
        w_rdata_next      = r_rdata;
        w_fetch_data_next = r_fetch_data;
        w_lsb_data_next   = r_lsb_data;
        w_ram_a_next      = r_ram_a;
        w_ram_dout_next   = r_ram_dout;
        w_fetch_ce_next   = 1'b0;
        w_lsb_ce_next     = 1'b0;
        w_rob_ce_next     = 1'b0;
        w_ram_wr_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_rob_ce) begin
                    w_state_next = S_WRITE;
                    w_addr_next  = in_rob_addr;
                    w_len_next   = f_len(in_rob_size);
                    w_wdata_next = in_rob_data;
                    // First byte goes out on the acceptance edge unless the IO port is full.
                    if (w_stall_new) begin
                        w_cnt_next = 3'd0;
                    end else begin
                        w_cnt_next      = 3'd1;
                        w_ram_wr_next   = 1'b1;
                        w_ram_a_next    = in_rob_addr;
                        w_ram_dout_next = in_rob_data[7:0];
                    end
                end else if (!in_rob_misbranch && (in_lsb_ce || in_fetcher_ce)) begin
                    w_state_next    = S_READ;
                    w_cnt_next      = 3'd0;
                    w_rdata_next    = '0;
                    w_is_fetch_next = !in_lsb_ce;
                    w_addr_next     = in_lsb_ce ? in_lsb_addr : in_fetcher_addr;
                    w_len_next      = in_lsb_ce ? f_len(in_lsb_size) : 3'd4;
                    w_signed_next   = in_lsb_ce && in_lsb_signed;
                    w_ram_a_next    = w_addr_next;
                end
            end
            S_READ: begin
                if (in_rob_misbranch) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 3'd0;
                end else begin
                    if (r_cnt != 3'd0) w_rdata_next = w_rdata_cap;
                    if (r_cnt == r_len) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = 3'd0;
                        if (r_is_fetch) begin
                            w_fetch_ce_next   = 1'b1;
                            w_fetch_data_next = w_ext;
                        end else begin
                            w_lsb_ce_next   = 1'b1;
                            w_lsb_data_next = w_ext;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 3'd1;
                        if ((r_cnt + 3'd1) < r_len) w_ram_a_next = r_addr + ADDR_W'(r_cnt + 3'd1);
                    end
                end
            end
            S_WRITE: begin
                if (r_cnt == r_len) begin
                    w_state_next  = S_IDLE;
                    w_cnt_next    = 3'd0;
                    w_rob_ce_next = 1'b1;
                end else if (!w_stall_cur) begin
                    w_ram_wr_next   = 1'b1;
                    w_ram_a_next    = r_addr + ADDR_W'(r_cnt);
                    w_ram_dout_next = r_wdata[8*r_cnt[1:0] +: 8];
                    w_cnt_next      = r_cnt + 3'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_signed     <= 1'b0;
            r_is_fetch   <= 1'b0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_fetch_data <= '0;
            r_lsb_data   <= '0;
            r_fetch_ce   <= 1'b0;
            r_lsb_ce     <= 1'b0;
            r_rob_ce     <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_ram_a      <= '0;
            r_ram_dout   <= '0;
        end else if (rdy) begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_len        <= w_len_next;
            r_addr       <= w_addr_next;
            r_signed     <= w_signed_next;
            r_is_fetch   <= w_is_fetch_next;
            r_wdata      <= w_wdata_next;
            r_rdata      <= w_rdata_next;
            r_fetch_data <= w_fetch_data_next;
            r_lsb_data   <= w_lsb_data_next;
            r_fetch_ce   <= w_fetch_ce_next;
            r_lsb_ce     <= w_lsb_ce_next;
            r_rob_ce     <= w_rob_ce_next;
            r_ram_wr     <= w_ram_wr_next;
            r_ram_a      <= w_ram_a_next;
            r_ram_dout   <= w_ram_dout_next;
        end
    end

    assign out_fetcher_ce   = r_fetch_ce;
    assign out_fetcher_data = r_fetch_data;
    assign out_lsb_ce       = r_lsb_ce;
    assign out_lsb_data     = r_lsb_data;
    assign out_rob_ce       = r_rob_ce;
    assign out_ram_wr       = r_ram_wr;
    assign out_ram_a        = r_ram_a;
    assign out_ram_dout     = r_ram_dout;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a two-edge-latency byte RAM model.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, in_rob_misbranch;
    logic        in_fetcher_ce;
    logic [31:0] in_fetcher_addr;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_data;
    logic        in_lsb_ce;
    logic [5:0]  in_lsb_size;
    logic        in_lsb_signed;
    logic [31:0] in_lsb_addr;
    logic        out_lsb_ce;
    logic [31:0] out_lsb_data;
    logic        in_rob_ce;
    logic [5:0]  in_rob_size;
    logic [31:0] in_rob_addr;
    logic [31:0] in_rob_data;
    logic        out_rob_ce;
    logic [7:0]  in_ram_din;
    logic [7:0]  out_ram_dout;
    logic [31:0] out_ram_a;
    logic        out_ram_wr;
    logic        in_io_buffer_full;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    // Registered-read RAM: address registered at edge E, data sampled by the DUT at E+2.
    always @(posedge clk) begin
        in_ram_din <= mem[out_ram_a[15:0]];
        if (out_ram_wr) mem[out_ram_a[15:0]] <= out_ram_dout;
    end

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_rob_misbranch(in_rob_misbranch),
        .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr),
        .out_fetcher_ce(out_fetcher_ce), .out_fetcher_data(out_fetcher_data),
        .in_lsb_ce(in_lsb_ce), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
        .in_lsb_addr(in_lsb_addr), .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
        .in_rob_ce(in_rob_ce), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
        .in_rob_data(in_rob_data), .out_rob_ce(out_rob_ce),
        .in_ram_din(in_ram_din), .out_ram_dout(out_ram_dout), .out_ram_a(out_ram_a),
        .out_ram_wr(out_ram_wr), .in_io_buffer_full(in_io_buffer_full)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++;
        if ({out_fetcher_ce, out_lsb_ce, out_rob_ce, out_ram_wr} !== 4'b0) begin
            errors++; $display("FAIL reset_ce: got %b expected 0000", {out_fetcher_ce, out_lsb_ce, out_rob_ce, out_ram_wr});
        end
        step(); step();
        checks++;
        if (out_ram_a !== 32'h0 || out_ram_dout !== 8'h0) begin
            errors++; $display("FAIL reset_ram: got a=%h dout=%h expected 0/0", out_ram_a, out_ram_dout);
        end
        checks++;
        if (out_fetcher_data !== 32'h0 || out_lsb_data !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h expected 0/0", out_fetcher_data, out_lsb_data);
        end
        rst = 1'b0;
        step();
        $display("reset released");
    endtask

    task automatic test_fetch;
        int done_at = -1;
        logic [31:0] held;
        in_fetcher_addr = 32'h100;
        in_fetcher_ce   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c < 4) begin
                checks++;
                if (out_ram_a !== 32'h100 + 32'(c)) begin
                    errors++; $display("FAIL fetch_addr%0d: got %h expected %h", c, out_ram_a, 32'h100 + 32'(c));
                end
            end
            if (done_at >= 0 && c == done_at + 1) begin
                checks++;
                if (out_fetcher_ce !== 1'b0 || out_fetcher_data !== held) begin
                    errors++; $display("FAIL fetch_pulse: got ce=%b data=%h expected ce=0 data=%h", out_fetcher_ce, out_fetcher_data, held);
                end
            end else if (out_fetcher_ce && done_at < 0) begin
                done_at = c;
                held = out_fetcher_data;
                in_fetcher_ce = 1'b0;
                checks++;
                if (out_fetcher_data !== 32'h00000513) begin
                    errors++; $display("FAIL fetch_data: got %h expected 00000513", out_fetcher_data);
                end
            end
        end
        in_fetcher_ce = 1'b0;
        checks++;
        if (done_at != 5) begin
            errors++; $display("FAIL fetch_latency: got %0d expected 5", done_at);
        end
        $display("fetch addr=00000100 data=%h latency=%0d", out_fetcher_data, done_at);
    endtask

    task automatic test_load;
        logic [5:0]  sz  [4] = '{6'd1, 6'd2, 6'd1, 6'd2};
        logic        sg  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exd [4] = '{32'hFFFFFF80, 32'h0000FF80, 32'h00000080, 32'hFFFFFF80};
        int          lat [4] = '{2, 3, 2, 3};
        for (int v = 0; v < 4; v++) begin
            int done_at = -1;
            logic [31:0] got = 32'h0;
            in_lsb_addr = 32'h20; in_lsb_size = sz[v]; in_lsb_signed = sg[v]; in_lsb_ce = 1'b1;
            for (int c = 0; c < 8; c++) begin
                step();
                if (out_lsb_ce && done_at < 0) begin
                    done_at = c; got = out_lsb_data; in_lsb_ce = 1'b0;
                end
            end
            in_lsb_ce = 1'b0;
            checks++;
            if (got !== exd[v]) begin
                errors++; $display("FAIL load%0d_data: got %h expected %h", v, got, exd[v]);
            end
            checks++;
            if (done_at != lat[v]) begin
                errors++; $display("FAIL load%0d_latency: got %0d expected %0d", v, done_at, lat[v]);
            end
            $display("load size=%0d signed=%0d data=%h latency=%0d", sz[v], sg[v], got, done_at);
        end
    endtask

    task automatic test_store;
        logic [7:0] eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int pulses = 0;
        in_rob_addr = 32'h40; in_rob_size = 6'd4; in_rob_data = 32'hDEADBEEF; in_rob_ce = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c < 4) begin
                checks++;
                if (out_ram_wr !== 1'b1 || out_ram_a !== 32'h40 + 32'(c) || out_ram_dout !== eb[c]) begin
                    errors++; $display("FAIL store_byte%0d: got wr=%b a=%h d=%h expected wr=1 a=%h d=%h",
                                       c, out_ram_wr, out_ram_a, out_ram_dout, 32'h40 + 32'(c), eb[c]);
                end
            end
            if (c == 4) begin
                checks++;
                if (out_rob_ce !== 1'b1 || out_ram_wr !== 1'b0) begin
                    errors++; $display("FAIL store_done: got ce=%b wr=%b expected ce=1 wr=0", out_rob_ce, out_ram_wr);
                end
            end
            if (out_rob_ce) begin pulses++; in_rob_ce = 1'b0; end
        end
        in_rob_ce = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL store_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if ({mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]} !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_mem: got %h expected deadbeef", {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]});
        end
        $display("store addr=00000040 data=deadbeef pulses=%0d", pulses);
    endtask

    task automatic test_priority;
        int rob_at = -1, lsb_at = -1, fet_at = -1;
        int rob_n = 0, lsb_n = 0, fet_n = 0;
        logic [31:0] lsb_d = 32'h0, fet_d = 32'h0;
        in_rob_addr = 32'h50; in_rob_size = 6'd1; in_rob_data = 32'h77; in_rob_ce = 1'b1;
        in_lsb_addr = 32'h20; in_lsb_size = 6'd1; in_lsb_signed = 1'b0; in_lsb_ce = 1'b1;
        in_fetcher_addr = 32'h100; in_fetcher_ce = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_rob_ce)     begin rob_n++; rob_at = c; in_rob_ce = 1'b0; end
            if (out_lsb_ce)     begin lsb_n++; lsb_at = c; lsb_d = out_lsb_data; in_lsb_ce = 1'b0; end
            if (out_fetcher_ce) begin fet_n++; fet_at = c; fet_d = out_fetcher_data; in_fetcher_ce = 1'b0; end
        end
        in_rob_ce = 1'b0; in_lsb_ce = 1'b0; in_fetcher_ce = 1'b0;
        checks++;
        if (rob_at != 1 || lsb_at != 4 || fet_at != 10) begin
            errors++; $display("FAIL prio_order: got rob=%0d lsb=%0d fetch=%0d expected 1/4/10", rob_at, lsb_at, fet_at);
        end
        checks++;
        if (rob_n != 1 || lsb_n != 1 || fet_n != 1) begin
            errors++; $display("FAIL prio_count: got %0d/%0d/%0d expected 1/1/1", rob_n, lsb_n, fet_n);
        end
        checks++;
        if (lsb_d !== 32'h80 || fet_d !== 32'h513) begin
            errors++; $display("FAIL prio_data: got lsb=%h fetch=%h expected 00000080/00000513", lsb_d, fet_d);
        end
        $display("priority rob@%0d lsb@%0d fetch@%0d", rob_at, lsb_at, fet_at);
    endtask

    task automatic test_misbranch_load;
        int lsb_n = 0, fet_at = -1;
        in_lsb_addr = 32'h100; in_lsb_size = 6'd4; in_lsb_signed = 1'b0; in_lsb_ce = 1'b1;
        step(); step();
        in_rob_misbranch = 1'b1; in_lsb_ce = 1'b0;
        step();
        in_rob_misbranch = 1'b0;
        in_fetcher_addr = 32'h100; in_fetcher_ce = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 0) begin
                checks++;
                if (out_ram_a !== 32'h100) begin
                    errors++; $display("FAIL misb_load_idle: got a=%h expected 00000100", out_ram_a);
                end
            end
            if (out_lsb_ce) lsb_n++;
            if (out_fetcher_ce && fet_at < 0) begin fet_at = c; in_fetcher_ce = 1'b0; end
        end
        in_fetcher_ce = 1'b0;
        checks++;
        if (lsb_n != 0) begin
            errors++; $display("FAIL misb_load_done: got %0d pulses expected 0", lsb_n);
        end
        checks++;
        if (fet_at != 5 || out_fetcher_data !== 32'h513) begin
            errors++; $display("FAIL misb_next_fetch: got lat=%0d data=%h expected 5/00000513", fet_at, out_fetcher_data);
        end
        $display("misbranch load aborted, pulses=%0d", lsb_n);
    endtask

    task automatic test_misbranch_store;
        int rob_at = -1;
        in_rob_addr = 32'h60; in_rob_size = 6'd4; in_rob_data = 32'h11223344; in_rob_ce = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_rob_misbranch = (c == 0 || c == 2);
            step();
            if (c == 0) begin
                checks++;
                if (out_ram_wr !== 1'b1) begin
                    errors++; $display("FAIL misb_store_accept: got wr=%b expected 1", out_ram_wr);
                end
            end
            if (out_rob_ce && rob_at < 0) begin rob_at = c; in_rob_ce = 1'b0; end
        end
        in_rob_misbranch = 1'b0; in_rob_ce = 1'b0;
        checks++;
        if (rob_at != 4) begin
            errors++; $display("FAIL misb_store_done: got %0d expected 4", rob_at);
        end
        checks++;
        if ({mem[16'h63], mem[16'h62], mem[16'h61], mem[16'h60]} !== 32'h11223344) begin
            errors++; $display("FAIL misb_store_mem: got %h expected 11223344", {mem[16'h63], mem[16'h62], mem[16'h61], mem[16'h60]});
        end
        $display("misbranch store completed at %0d", rob_at);
    endtask

    task automatic test_io_stall;
        int first_wr = -1, wr_n = 0, rob_at = -1;
`ifdef MEM_IO_STALL_EN
        int exp_wr = 3, exp_done = 4;
`else
        int exp_wr = 0, exp_done = 1;
`endif
        in_rob_addr = 32'h30000; in_rob_size = 6'd1; in_rob_data = 32'h41; in_rob_ce = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_io_buffer_full = (c < 3);
            step();
            if (out_ram_wr) begin
                wr_n++;
                if (first_wr < 0) begin
                    first_wr = c;
                    checks++;
                    if (out_ram_a !== 32'h30000 || out_ram_dout !== 8'h41) begin
                        errors++; $display("FAIL io_write: got a=%h d=%h expected 00030000/41", out_ram_a, out_ram_dout);
                    end
                end
            end
            if (out_rob_ce && rob_at < 0) begin rob_at = c; in_rob_ce = 1'b0; end
        end
        in_io_buffer_full = 1'b0; in_rob_ce = 1'b0;
        checks++;
        if (first_wr != exp_wr || wr_n != 1) begin
            errors++; $display("FAIL io_stall: got first=%0d writes=%0d expected %0d/1", first_wr, wr_n, exp_wr);
        end
        checks++;
        if (rob_at != exp_done) begin
            errors++; $display("FAIL io_done: got %0d expected %0d", rob_at, exp_done);
        end
        $display("io store first_write=%0d done=%0d", first_wr, rob_at);
    endtask

    task automatic test_rdy_hold;
        logic [31:0] ea [4] = '{32'h100, 32'h101, 32'h101, 32'h101};
        int fet_at = -1;
        in_fetcher_addr = 32'h100; in_fetcher_ce = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rdy = !(c == 2 || c == 3);
            step();
            if (c < 4) begin
                checks++;
                if (out_ram_a !== ea[c]) begin
                    errors++; $display("FAIL rdy_addr%0d: got %h expected %h", c, out_ram_a, ea[c]);
                end
            end
            if (out_fetcher_ce && fet_at < 0) begin fet_at = c; in_fetcher_ce = 1'b0; end
        end
        rdy = 1'b1; in_fetcher_ce = 1'b0;
        checks++;
        if (fet_at != 7) begin
            errors++; $display("FAIL rdy_latency: got %0d expected 7", fet_at);
        end
        $display("rdy-stalled fetch latency=%0d", fet_at);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h100] = 8'h13; mem[16'h101] = 8'h05; mem[16'h102] = 8'h00; mem[16'h103] = 8'h00;
        mem[16'h20]  = 8'h80; mem[16'h21]  = 8'hFF;
        rst = 1'b1; rdy = 1'b1; in_rob_misbranch = 1'b0; in_io_buffer_full = 1'b0;
        in_fetcher_ce = 1'b0; in_fetcher_addr = 32'h0;
        in_lsb_ce = 1'b0; in_lsb_size = 6'd0; in_lsb_signed = 1'b0; in_lsb_addr = 32'h0;
        in_rob_ce = 1'b0; in_rob_size = 6'd0; in_rob_addr = 32'h0; in_rob_data = 32'h0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_priority();
        test_misbranch_load();
        test_misbranch_store();
        test_io_stall();
        test_rdy_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single owner of the byte-wide RAM port.
- Arbitrates three requesters and serialises each into byte-at-a-time RAM cycles:
  - instruction fetcher: 4-byte read
  - load/store buffer: 1/2/4-byte load, signed or unsigned
  - ROB commit: 1/2/4-byte store
- Sits between fetcher/LSB/ROB and the top-level RAM pins.
- Returns assembled, sign-extended words and one-cycle done pulses.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width returned to requesters.
- IO_SEL_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region (used only under the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- in_rob_misbranch  in  1  flush of speculative fetch and load.
- in_fetcher_ce  in  1  fetch request, level, held until done.
- in_fetcher_addr  in  ADDR_W  fetch byte address.
- out_fetcher_ce  out  1  fetch done pulse.
- out_fetcher_data  out  DATA_W  fetched instruction word.
- in_lsb_ce  in  1  load request, level.
- in_lsb_size  in  6  byte count: 1, 2 or 4.
- in_lsb_signed  in  1  1 = sign-extend.
- in_lsb_addr  in  ADDR_W  load address.
- out_lsb_ce  out  1  load done pulse.
- out_lsb_data  out  DATA_W  extended load value.
- in_rob_ce  in  1  store request, level.
- in_rob_size  in  6  byte count: 1, 2 or 4.
- in_rob_addr  in  ADDR_W  store address.
- in_rob_data  in  DATA_W  store value.
- out_rob_ce  out  1  store done pulse.
- in_ram_din  in  8  RAM read data; valid two edges after its address is registered.
- out_ram_dout  out  8  RAM write byte.
- out_ram_a  out  ADDR_W  RAM byte address.
- out_ram_wr  out  1  1 = write, 0 = read.
- in_io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All done pulses 0.
  - out_ram_wr 0, out_ram_a 0, out_ram_dout 0.
  - Data outputs 0; byte counter 0.
- rdy=0: every register holds, including state, counters and RAM outputs.
- States:
  - IDLE: arbitration.
  - READ: fetch or load in progress.
  - WRITE: store in progress.
- Arbitration in IDLE, sampled each edge:
  - Priority: rob store > lsb load > fetch.
  - The winner's address, size, signed flag and data are latched; the requester is not resampled while busy.
  - A requester is not accepted on the same edge that its done pulse is driven.
- READ of N bytes (fetch N=4), acceptance at edge E0:
  - out_ram_a = addr+i after edge Ei, for i = 0..N-1.
  - Byte i is captured from in_ram_din at edge E(i+2).
  - Done pulse and data are driven after edge E(N+1); state returns to IDLE.
  - 4-byte latency is 5 cycles from acceptance.
- WRITE of N bytes:
  - out_ram_wr=1, out_ram_a=addr+i, out_ram_dout=data[8i+7:8i] after edge Ei.
  - out_rob_ce pulse after edge EN, with out_ram_wr=0 at the same time.
- Byte order: little-endian.
  - Loads with N<4: signed → upper bits copy bit 8N-1; unsigned → zero-filled.
- Size encoding: any in_*_size other than 1 or 2 is treated as 4.
- Done pulses: exactly one cycle high.
  - Data outputs hold their last value until the next done.
- Address arithmetic: wraps modulo 2^ADDR_W.
- Misbranch (in_rob_misbranch=1 at an edge):
  - Active READ for fetch or load is aborted: IDLE next, no done pulse, partial data discarded.
  - Fetch/load requests are not accepted that edge.
  - Active WRITE continues to completion; a store request may still be accepted.
- Simultaneous events:
  - Store request during misbranch in IDLE: accepted.
  - Done pulse and new acceptance never occur on the same edge.
  - The earliest re-acceptance is the edge after done.
- out_ram_wr is 0 in IDLE and in READ.

Optional Feature:
- MEM_IO_STALL_EN defined:
  - In WRITE, if in_io_buffer_full=1 and addr[17:16]==IO_SEL_HI, the current byte is not issued: out_ram_wr=0 that cycle, and the counter and address hold.
  - Issuing resumes on the first edge with in_io_buffer_full=0.
- Undefined: in_io_buffer_full is ignored; stores never stall.

Test Plan:
- Fetch, RAM[0x100..0x103] = 13 05 00 00, in_fetcher_ce held → out_fetcher_data=0x00000513, out_fetcher_ce pulse 5 cycles after acceptance; out_ram_a steps 0x100..0x103.
- Load LB signed at 0x20 holding 0x80 → out_lsb_data=0xFFFFFF80. LHU at 0x20 holding 80 FF → 0x0000FF80.
- Store SW 0xDEADBEEF to 0x40 → out_ram_wr=1 for 4 cycles with dout EF, BE, AD, DE at 0x40..0x43; out_rob_ce 1 cycle later.
- Fetch, load and store all raised in the same cycle → store served first, then load, then fetch; each done pulse fires exactly once.
- Misbranch 2 cycles into a 4-byte load → no out_lsb_ce, state IDLE next edge. Repeat during a store → store completes, out_rob_ce pulses.
- MEM_IO_STALL_EN: SB 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → out_ram_wr stays 0 for 3 cycles, then one write; done follows. Without the macro → write occurs immediately.
